fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 StallF  in  1  hazard unit: do not launch a new fetch.
REQ-005 StallD  in  1  hazard unit: hold decode register.
REQ-006 FlushD  in  1  hazard unit: invalidate decode register.
REQ-007 BranchTakenE, BranchTargetE  in  1, 32  execute-stage redirect.
REQ-008 PCSrcW, ResultW  in  1, 32  writeback redirect (write to r15).
REQ-009 imem_req, imem_addr  out  1, 32  instruction-memory request; addr word-aligned.
REQ-010 imem_ack, imem_rdata  in  1, 32  memory response; rdata valid only while ack=1.
REQ-011 InstrD, PCPlus8D, ValidD  out  32, 32, 1  decode-stage instruction, its address+8 (r15 value), valid flag.
REQ-012 FetchBusyF  out  1  high in BUSY or DROP; stall request to hazard unit.

Function
REQ-013 State registers SHALL be PCF (next fetch address), AddrReg (outstanding address), Buf/BufPC (skid buffer), state in {IDLE, BUSY, DROP, HOLD}.
REQ-014 imem_req SHALL be 1 exactly in BUSY and DROP; imem_addr SHALL equal AddrReg and stay stable until the ack.
REQ-015 Redirect SHALL be PCSrcW | BranchTakenE; target SHALL be ResultW when PCSrcW=1, else BranchTargetE (writeback wins).
REQ-016 Launch: AddrReg<=PCF, PCF<=PCF+4 (32-bit wrap, 32'hFFFF_FFFC -> 0), state->BUSY.
REQ-017 IDLE: redirect -> PCF<=target, stay IDLE; else !StallF -> launch; else hold.
REQ-018 BUSY, no ack: redirect -> PCF<=target, ->DROP; else stay.
REQ-019 BUSY, ack, redirect: data discarded, PCF<=target, ->IDLE.
REQ-020 BUSY, ack, !StallD: deliver (InstrD<=rdata, PCPlus8D<=AddrReg+8, ValidD<=1); then launch again same edge if !StallF, else ->IDLE.
REQ-021 BUSY, ack, StallD: Buf<=rdata, BufPC<=AddrReg, ->HOLD.
REQ-022 DROP: ack -> data discarded, ->IDLE; redirect in DROP only updates PCF.
REQ-023 HOLD: redirect -> buffer dropped, PCF<=target, ->IDLE; else !StallD -> deliver Buf/BufPC+8, ->IDLE.
REQ-024 Decode register priority: redirect or FlushD -> ValidD<=0, InstrD<=0; else StallD -> hold; else deliver or bubble (ValidD<=0, InstrD<=0).
REQ-025 FlushD together with StallD SHALL clear (flush wins); FlushD SHALL NOT affect FSM or buffer.
REQ-026 Each fetched instruction SHALL reach decode at most once and in program order; no instruction from a discarded fetch SHALL reach decode.
REQ-027 Latency: ack at edge N, StallD=0 -> ValidD=1 after edge N; back-to-back single-cycle acks give 1 instruction/cycle.

Reset
REQ-028 reset SHALL force asynchronously: state=IDLE, PCF=RESET_PC, AddrReg=RESET_PC, Buf=0, InstrD=0, PCPlus8D=0, ValidD=0, imem_req=0, FetchBusyF=0.
REQ-029 reset mid-fetch SHALL abandon the outstanding request; an ack in the first cycle after release SHALL be ignored (IDLE).

Structure
REQ-030 Shared package SHALL hold the state enum, RESET_PC default, and PC_STEP=4.
REQ-031 Decode register SHALL be a sub-module flopenrc (enable + synchronous clear + async reset, parameterised width), instantiated once with width 65.

Verification
REQ-032 Reset release, ack every cycle -> imem_addr 0,4,8,...; InstrD follows; PCPlus8D 8,12,16.
REQ-033 Ack delayed 3 cycles at addr 0x10 -> imem_req/addr stable 3 cycles, FetchBusyF=1, ValidD=1 only after ack.
REQ-034 StallD=1 at ack of 0x20 for 2 cycles -> HOLD, imem_req=0; on release InstrD=0x20 data, PCPlus8D=0x28, no duplicate.
REQ-035 BranchTakenE=1, target 0x100, during outstanding fetch of 0x30 -> DROP, 0x30 data discarded, next imem_addr=0x100.
REQ-036 PCSrcW=1 (ResultW=0x200) and BranchTakenE=1 (0x300) same cycle -> next fetch 0x200, ValidD=0.
REQ-037 reset asserted in BUSY, ack arrives first cycle after release -> ignored, ValidD=0, first fetch RESET_PC.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: FSM encoding, reset PC default and PC increment.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DROP = 2'd2,
        S_HOLD = 2'd3
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_stage_flopenrc.sv
// Resettable register with enable and synchronous clear; clear beats enable.
module flopenrc #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Storage: async reset, then clear, then load when enabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch with a single outstanding memory request, a one-entry skid
// buffer for decode stalls, and discard of fetches overtaken by a redirect.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        BranchTakenE,
    input  logic [31:0] BranchTargetE,
    input  logic        PCSrcW,
    input  logic [31:0] ResultW,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus8D,
    output logic        ValidD,
    output logic        FetchBusyF
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pcf_q, pcf_d;
    logic [31:0]  addr_q, addr_d;
    logic [31:0]  buf_q, buf_d;
    logic [31:0]  bufpc_q, bufpc_d;
    logic         imem_req_q, imem_req_d;
    logic         redirect_s;
    logic [31:0]  target_s;
    logic         deliver_s;
    logic [31:0]  dlv_instr_s, dlv_pc_s;
    logic [64:0]  dec_d_s, dec_q_s;

    // Redirect select: a writeback write to r15 overrides an execute branch.
    always_comb begin
        redirect_s = PCSrcW | BranchTakenE;
        if (PCSrcW) begin
            target_s = word_align(ResultW);
        end else begin
            target_s = word_align(BranchTargetE);
        end
    end

    // Next-state logic for the fetch FSM, PC, outstanding address and skid buffer.
    always_comb begin
        state_d     = state_q;
        pcf_d       = pcf_q;
        addr_d      = addr_q;
        buf_d       = buf_q;
        bufpc_d     = bufpc_q;
        deliver_s   = 1'b0;
        dlv_instr_s = imem_rdata;
        dlv_pc_s    = addr_q;
        case (state_q)
            S_IDLE: begin
                if (redirect_s) begin
                    pcf_d = target_s;
                end else if (!StallF) begin
                    addr_d  = pcf_q;
                    pcf_d   = pcf_q + PC_STEP;
                    state_d = S_BUSY;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                if (!imem_ack) begin
                    if (redirect_s) begin
                        pcf_d   = target_s;
                        state_d = S_DROP;
                    end else begin
                        state_d = S_BUSY;
                    end
                end else if (redirect_s) begin
                    pcf_d   = target_s;
                    state_d = S_IDLE;
                end else if (!StallD) begin
                    deliver_s = 1'b1;
                    if (!StallF) begin
                        addr_d  = pcf_q;
                        pcf_d   = pcf_q + PC_STEP;
                        state_d = S_BUSY;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    buf_d   = imem_rdata;
                    bufpc_d = addr_q;
                    state_d = S_HOLD;
                end
            end
            S_DROP: begin
                // The in-flight response belongs to the abandoned path.
                if (redirect_s) begin
                    pcf_d = target_s;
                end else begin
                    pcf_d = pcf_q;
                end
                if (imem_ack) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DROP;
                end
            end
            S_HOLD: begin
                if (redirect_s) begin
                    pcf_d   = target_s;
                    state_d = S_IDLE;
                end else if (!StallD) begin
                    deliver_s   = 1'b1;
                    dlv_instr_s = buf_q;
                    dlv_pc_s    = bufpc_q;
                    state_d     = S_IDLE;
                end else begin
                    state_d = S_HOLD;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        imem_req_d = (state_d == S_BUSY) || (state_d == S_DROP);
    end

    // FSM and fetch-side state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pcf_q      <= RESET_PC;
            addr_q     <= RESET_PC;
            buf_q      <= 32'd0;
            bufpc_q    <= 32'd0;
            imem_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pcf_q      <= pcf_d;
            addr_q     <= addr_d;
            buf_q      <= buf_d;
            bufpc_q    <= bufpc_d;
            imem_req_q <= imem_req_d;
        end
    end

    // Decode register contents: a delivered instruction or a bubble.
    always_comb begin
        if (deliver_s) begin
            dec_d_s = {1'b1, dlv_instr_s, dlv_pc_s + 32'd8};
        end else begin
            dec_d_s = 65'd0;
        end
    end

    flopenrc #(.WIDTH(65)) u_decode_reg (
        .clk   (clk),
        .reset (reset),
        .en    (~StallD),
        .clr   (redirect_s | FlushD),
        .d     (dec_d_s),
        .q     (dec_q_s)
    );

    assign {ValidD, InstrD, PCPlus8D} = dec_q_s;
    assign imem_req   = imem_req_q;
    assign FetchBusyF = imem_req_q;
    assign imem_addr  = addr_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a latency-configurable memory model, a
// scoreboard queue of expected decode outputs, and a monitor that pops it.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset, StallF, StallD, FlushD, BranchTakenE, PCSrcW;
    logic [31:0] BranchTargetE, ResultW;
    logic        imem_req, imem_ack, ValidD, FetchBusyF;
    logic [31:0] imem_addr, imem_rdata, InstrD, PCPlus8D;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    int          mem_lat = 0;
    int          wait_cnt = 0;
    logic        stray_ack = 1'b0;
    logic        mon_stall;
    logic [63:0] mon_e;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .BranchTakenE(BranchTakenE), .BranchTargetE(BranchTargetE),
        .PCSrcW(PCSrcW), .ResultW(ResultW),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .InstrD(InstrD), .PCPlus8D(PCPlus8D), .ValidD(ValidD), .FetchBusyF(FetchBusyF)
    );

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic push_exp(input logic [31:0] addr, input logic [31:0] pc8);
        exp_q.push_back({mdata(addr), pc8});
    endtask

    task automatic redir(input logic [31:0] t);
        BranchTakenE  = 1'b1;
        BranchTargetE = t;
        tick;
        BranchTakenE  = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain actual pending=%0d required pending=0", name, exp_q.size());
        end
        repeat (3) tick;
    endtask

    // Instruction memory: ack after mem_lat waiting cycles, data only while ack.
    initial begin
        imem_ack   = 1'b0;
        imem_rdata = 32'h0BAD_0BAD;
        forever begin
            @(posedge clk);
            #2;
            if (stray_ack) begin
                imem_ack   = 1'b1;
                imem_rdata = 32'hDEAD_BEEF;
                wait_cnt   = 0;
            end else if (imem_req) begin
                if (wait_cnt >= mem_lat) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mdata(imem_addr);
                    wait_cnt   = 0;
                end else begin
                    imem_ack   = 1'b0;
                    imem_rdata = 32'h0BAD_0BAD;
                    wait_cnt++;
                end
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = 32'h0BAD_0BAD;
                wait_cnt   = 0;
            end
        end
    end

    // Monitor: a newly loaded valid decode entry must match the queue head.
    initial begin
        forever begin
            @(posedge clk);
            mon_stall = StallD;
            #1;
            if (ValidD === 1'b1 && mon_stall === 1'b0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_delivery actual InstrD=%h PCPlus8D=%h required no delivery",
                             InstrD, PCPlus8D);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("InstrD", InstrD, mon_e[63:32]);
                    chk("PCPlus8D", PCPlus8D, mon_e[31:0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; StallF = 1'b1; StallD = 1'b0; FlushD = 1'b0;
        BranchTakenE = 1'b0; BranchTargetE = 32'd0; PCSrcW = 1'b0; ResultW = 32'd0;
        repeat (2) tick;
        chk1("rst_req", imem_req, 1'b0);
        chk1("rst_busy", FetchBusyF, 1'b0);
        chk1("rst_valid", ValidD, 1'b0);
        chk("rst_instr", InstrD, 32'd0);
        chk("rst_pc8", PCPlus8D, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        reset = 1'b0;
        tick;

        // Streaming fetch with an ack every cycle.
        push_exp(32'h0, 32'h8); push_exp(32'h4, 32'hC); push_exp(32'h8, 32'h10);
        StallF = 1'b0;
        tick; chk("t1_addr0", imem_addr, 32'h0); chk1("t1_req", imem_req, 1'b1);
        tick; chk("t1_addr4", imem_addr, 32'h4);
        tick; chk("t1_addr8", imem_addr, 32'h8);
        StallF = 1'b1;
        wait_drain("t1");

        // Three-cycle memory latency at 0x10.
        redir(32'h10);
        mem_lat = 3;
        push_exp(32'h10, 32'h18);
        StallF = 1'b0;
        tick;
        StallF = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk1("t2_req", imem_req, 1'b1);
            chk("t2_addr", imem_addr, 32'h10);
            chk1("t2_busy", FetchBusyF, 1'b1);
            chk1("t2_novalid", ValidD, 1'b0);
            tick;
        end
        mem_lat = 0;
        wait_drain("t2");

        // Decode stall at the ack of 0x20 parks the word in the skid buffer.
        redir(32'h20);
        push_exp(32'h20, 32'h28);
        StallF = 1'b0; StallD = 1'b1;
        tick;
        StallF = 1'b1;
        tick;
        chk1("t3_hold_req", imem_req, 1'b0);
        chk1("t3_hold_busy", FetchBusyF, 1'b0);
        chk1("t3_hold_valid", ValidD, 1'b0);
        tick;
        chk1("t3_hold_req2", imem_req, 1'b0);
        chk1("t3_hold_valid2", ValidD, 1'b0);
        StallD = 1'b0;
        wait_drain("t3");

        // Branch while 0x30 is outstanding: its data must be dropped.
        redir(32'h30);
        mem_lat = 3;
        StallF = 1'b0;
        tick;
        StallF = 1'b1; BranchTakenE = 1'b1; BranchTargetE = 32'h100;
        tick;
        BranchTakenE = 1'b0;
        chk1("t4_drop_req", imem_req, 1'b1);
        chk("t4_drop_addr", imem_addr, 32'h30);
        chk1("t4_drop_busy", FetchBusyF, 1'b1);
        for (int i = 0; i < 20 && imem_req; i++) tick;
        chk1("t4_drop_done", imem_req, 1'b0);
        mem_lat = 0;
        push_exp(32'h100, 32'h108);
        StallF = 1'b0;
        tick;
        chk("t4_next_addr", imem_addr, 32'h100);
        StallF = 1'b1;
        wait_drain("t4");

        // Writeback and execute redirect together at an ack: writeback wins.
        StallF = 1'b0;
        tick;
        StallF = 1'b1;
        PCSrcW = 1'b1; ResultW = 32'h200; BranchTakenE = 1'b1; BranchTargetE = 32'h300;
        tick;
        PCSrcW = 1'b0; BranchTakenE = 1'b0;
        chk1("t5_valid", ValidD, 1'b0);
        chk1("t5_req", imem_req, 1'b0);
        push_exp(32'h200, 32'h208);
        StallF = 1'b0;
        tick;
        chk("t5_addr", imem_addr, 32'h200);
        StallF = 1'b1;
        wait_drain("t5");

        // Reset in BUSY followed by a stray ack in the first cycle after release.
        mem_lat = 5;
        StallF = 1'b0;
        tick;
        StallF = 1'b1;
        chk1("t6_busy", imem_req, 1'b1);
        reset = 1'b1;
        #1;
        chk1("t6_async_req", imem_req, 1'b0);
        chk("t6_async_addr", imem_addr, 32'h0);
        stray_ack = 1'b1;
        tick;
        reset = 1'b0;
        stray_ack = 1'b0;
        tick;
        chk1("t6_stray_valid", ValidD, 1'b0);
        chk1("t6_stray_req", imem_req, 1'b0);
        mem_lat = 0;
        push_exp(32'h0, 32'h8);
        StallF = 1'b0;
        tick;
        chk("t6_first_addr", imem_addr, 32'h0);
        chk1("t6_first_req", imem_req, 1'b1);
        StallF = 1'b1;

        // Flush together with stall clears a held decode entry.
        for (int i = 0; i < 20 && ValidD !== 1'b1; i++) tick;
        StallD = 1'b1;
        tick;
        chk1("t7_held_valid", ValidD, 1'b1);
        chk("t7_held_instr", InstrD, 32'hA5A5_0000);
        FlushD = 1'b1;
        tick;
        chk1("t7_flush_valid", ValidD, 1'b0);
        chk("t7_flush_instr", InstrD, 32'd0);
        FlushD = 1'b0; StallD = 1'b0;
        wait_drain("t7");

        // PC wraps from the top word to zero.
        redir(32'hFFFF_FFFC);
        push_exp(32'hFFFF_FFFC, 32'h0000_0004);
        push_exp(32'h0, 32'h8);
        StallF = 1'b0;
        tick;
        chk("t8_addr_top", imem_addr, 32'hFFFF_FFFC);
        tick;
        chk("t8_addr_wrap", imem_addr, 32'h0);
        StallF = 1'b1;
        wait_drain("t8");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
